// File: rtl/map_write_arbiter.sv
// Round-robin arbiter for the tile-map write port. Writes are granted only
// during vertical blanking, and at most MAX_WR writes are granted per frame.
module map_write_arbiter #(
  parameter int N_REQ  = 3,   // 0 = level loader, 1 = pacman, 2 = ghosts
  parameter int ROWS   = 36,
  parameter int COLS   = 28,
  parameter int MAX_WR = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vblank,
  input  logic               i_frame_start,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*6-1:0] i_req_row,
  input  logic [N_REQ*5-1:0] i_req_col,
  input  logic [N_REQ*8-1:0] i_req_tile,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_err,
  output logic               o_we,
  output logic [5:0]         o_wr_row,
  output logic [4:0]         o_wr_col,
  output logic [7:0]         o_wr_tile,
  output logic               o_busy,
  output logic [4:0]         o_wr_count
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WRITE, S_COOL} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [5:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [7:0]    tile_q, tile_d;
  logic [4:0]    cnt_q, cnt_d;

  logic          found;
  logic [PW-1:0] pick;
  logic          enter_ok;
  logic          wr_ok;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    logic [PW:0] idx;
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!found && i_req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign enter_ok = i_vblank && (|i_req) && (cnt_q < 5'(MAX_WR));
  assign wr_ok    = (row_q < 6'(ROWS)) && (col_q < 5'(COLS));

  // Next-state, request capture, pointer and per-frame write count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    row_d   = row_q;
    col_d   = col_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    if (i_frame_start) cnt_d = '0;
    unique case (state_q)
      S_IDLE:  if (enter_ok) state_d = S_ARB;
      S_ARB: begin
        if (i_vblank && found) begin
          sel_d   = pick;
          row_d   = i_req_row[int'(pick)*6 +: 6];
          col_d   = i_req_col[int'(pick)*5 +: 5];
          tile_d  = i_req_tile[int'(pick)*8 +: 8];
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // A frame start coinciding with a valid write leaves exactly that write counted.
        if (wr_ok) begin
          if (i_frame_start)              cnt_d = 5'd1;
          else if (cnt_q < 5'(MAX_WR))    cnt_d = cnt_q + 5'd1;
        end
        ptr_d   = (sel_q == PW'(N_REQ-1)) ? '0 : sel_q + PW'(1);
        state_d = S_COOL;
      end
      S_COOL:  state_d = enter_ok ? S_ARB : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tile_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    o_gnt = '0;
    if (state_q == S_WRITE) o_gnt[sel_q] = 1'b1;
  end

  assign o_we       = (state_q == S_WRITE) && wr_ok;
  assign o_err      = (state_q == S_WRITE) && !wr_ok;
  assign o_wr_row   = o_we ? row_q  : '0;
  assign o_wr_col   = o_we ? col_q  : '0;
  assign o_wr_tile  = o_we ? tile_q : '0;
  assign o_busy     = (state_q != S_IDLE);
  assign o_wr_count = cnt_q;
endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: a cycle-level model checked on every
// negative edge, plus literal expectations for each scenario.
module tb_map_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank, frame_start;
  logic [2:0]  req;
  logic [17:0] req_row;
  logic [14:0] req_col;
  logic [23:0] req_tile;
  logic [2:0]  gnt;
  logic        err, we, busy;
  logic [5:0]  wr_row;
  logic [4:0]  wr_col, wr_count;
  logic [7:0]  wr_tile;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  map_write_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vblank(vblank), .i_frame_start(frame_start),
    .i_req(req), .i_req_row(req_row), .i_req_col(req_col), .i_req_tile(req_tile),
    .o_gnt(gnt), .o_err(err), .o_we(we), .o_wr_row(wr_row), .o_wr_col(wr_col),
    .o_wr_tile(wr_tile), .o_busy(busy), .o_wr_count(wr_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  // Tracks which phase of a grant sequence the block is in: looking at the
  // requests, presenting a grant, or resting for one cycle afterwards.
  logic m_look, m_show, m_rest;
  int   m_k, m_ptr, m_cnt;
  int   m_row, m_col, m_tile;
  int   m_pick;
  logic m_valid;

  function automatic int rr_pick(input logic [2:0] r, input int from);
    for (int i = 0; i < 3; i++)
      if (r[(from + i) % 3]) return (from + i) % 3;
    return 0;
  endfunction

  assign m_pick  = rr_pick(req, m_ptr);
  assign m_valid = m_show && (m_row < 36) && (m_col < 28);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_look <= 1'b0; m_show <= 1'b0; m_rest <= 1'b0;
      m_k <= 0; m_ptr <= 0; m_cnt <= 0;
      m_row <= 0; m_col <= 0; m_tile <= 0;
    end else begin
      if (frame_start)                 m_cnt <= m_valid ? 1 : 0;
      else if (m_valid && m_cnt < 16)  m_cnt <= m_cnt + 1;
      m_look <= 1'b0; m_show <= 1'b0; m_rest <= 1'b0;
      if (m_show) begin
        m_ptr  <= (m_k + 1) % 3;
        m_rest <= 1'b1;
      end else if (m_look) begin
        if (vblank && req != 3'b000) begin
          m_show <= 1'b1;
          m_k    <= m_pick;
          m_row  <= int'(req_row[6*m_pick +: 6]);
          m_col  <= int'(req_col[5*m_pick +: 5]);
          m_tile <= int'(req_tile[8*m_pick +: 8]);
        end
      end else begin
        m_look <= vblank && (req != 3'b000) && (m_cnt < 16);
      end
    end
  end

  logic [2:0]  e_gnt;
  logic [29:0] e_vec, a_vec;
  assign e_gnt = m_show ? (3'b001 << m_k) : 3'b000;
  assign e_vec = {e_gnt, m_show && !m_valid, m_valid,
                  m_valid ? 6'(m_row) : 6'd0, m_valid ? 5'(m_col) : 5'd0,
                  m_valid ? 8'(m_tile) : 8'd0, m_look | m_show | m_rest, 5'(m_cnt)};
  assign a_vec = {gnt, err, we, wr_row, wr_col, wr_tile, busy, wr_count};

  always @(negedge clk) chk("cycle", 32'(a_vec), 32'(e_vec));

  // ---------------- stimulus ----------------
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int row, input int col, input int tile);
    req_row[6*k +: 6]  = 6'(row);
    req_col[5*k +: 5]  = 5'(col);
    req_tile[8*k +: 8] = 8'(tile);
  endtask

  // Counts clock edges until a grant is visible; -1 when the bound runs out.
  task automatic wait_gnt(input int bound, output int n);
    n = -1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt != 3'b000) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int order [4] = '{0, 1, 2, 0};
    rst_n = 1'b0; vblank = 1'b0; frame_start = 1'b0; req = '0;
    req_row = '0; req_col = '0; req_tile = '0;
    go(3);
    @(negedge clk);
    chk("reset_out", {gnt, we, err, busy, wr_count}, 0);
    go(1);
    rst_n = 1'b1;

    // single pacman write
    set_req(1, 5, 7, 8'h00);
    vblank = 1'b1;
    req = 3'b010;
    wait_gnt(8, n);
    chk("t2_lat", n, 2);
    chk("t2_gnt", gnt, 3'b010);
    chk("t2_we", we, 1);
    chk("t2_row", wr_row, 5);
    chk("t2_col", wr_col, 7);
    chk("t2_tile", wr_tile, 8'h00);
    go(1);
    req = 3'b000;
    @(negedge clk);
    chk("t2_cnt", wr_count, 1);

    // reset in the middle of a write cycle
    set_req(0, 1, 1, 8'h55);
    req = 3'b001;
    wait_gnt(8, n);
    chk("t1_we_before", we, 1);
    #1 rst_n = 1'b0;
    #1 chk("t1_we_now", {gnt, we}, 0);
    req = 3'b000;
    go(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_cnt", wr_count, 0);
    chk("t1_busy", busy, 0);

    // all three requesting: order 0,1,2,0 spaced 3 cycles
    for (int k = 0; k < 3; k++) set_req(k, k + 1, k + 2, 8'h10 + k);
    go(1);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(8, n);
      chk("t3_lat", n, (i == 0) ? 2 : 3);
      chk("t3_gnt", gnt, 3'b001 << order[i]);
    end
    req = 3'b000;
    go(2);
    @(negedge clk);
    chk("t3_cnt", wr_count, 4);

    // no grants outside blanking
    vblank = 1'b0;
    req = 3'b111;
    wait_gnt(6, n);
    chk("t4_nognt", n, -1);
    vblank = 1'b1;
    wait_gnt(8, n);
    chk("t4_lat", n, 2);
    chk("t4_gnt", gnt, 3'b010);
    req = 3'b000;
    go(2);

    // out-of-range row
    set_req(2, 36, 3, 8'hAA);
    req = 3'b100;
    wait_gnt(8, n);
    chk("t5_gnt", gnt, 3'b100);
    chk("t5_err", err, 1);
    chk("t5_we", we, 0);
    req = 3'b000;
    go(2);
    @(negedge clk);
    chk("t5_cnt", wr_count, 5);

    // per-frame budget
    go(1);
    frame_start = 1'b1;
    go(1);
    frame_start = 1'b0;
    @(negedge clk);
    chk("t6_clr", wr_count, 0);
    set_req(2, 9, 9, 8'h22);
    req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      wait_gnt(8, n);
      chk("t6_gnt", n > 0, 1);
    end
    go(2);
    @(negedge clk);
    chk("t6_full", wr_count, 16);
    wait_gnt(12, n);
    chk("t6_stop", n, -1);
    frame_start = 1'b1;
    go(1);
    frame_start = 1'b0;
    wait_gnt(8, n);
    chk("t6_resume", n, 2);
    wait_gnt(8, n);
    chk("t6_lat2", n, 3);
    frame_start = 1'b1;   // coincides with this write
    go(1);
    frame_start = 1'b0;
    @(negedge clk);
    chk("t6_fs_wr", wr_count, 1);
    req = 3'b000;
    vblank = 1'b0;
    go(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
